// File: rtl/ahb_lite_wait_slave.sv
// ahb_lite_wait_slave: AHB-Lite register-bank slave with WAIT_STATES wait cycles per OKAY transfer and a two-cycle ERROR response
module ahb_lite_wait_slave #(
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic        HREADYS,
    input  logic [31:0] HWDATAS,
    output logic        HREADYOUTS,
    output logic        HRESPS,
    output logic [31:0] HRDATAS
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WAIT = 3'd1;
    localparam logic [2:0] LAST = 3'd2;
    localparam logic [2:0] ERR1 = 3'd3;
    localparam logic [2:0] ERR2 = 3'd4;
    localparam logic [1:0] CNT_INIT = 2'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [2:0] OK_STATE = WAIT_STATES > 0 ? WAIT : LAST;
    logic [2:0]  state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [5:0]  addr_q;
    logic        write_q;
    logic [2:0]  size_q;
    logic [31:0] mem [16];
    logic        accept, bad;
    logic [3:0]  be;
    logic        unused;
    assign unused = &{1'b0, HADDRS[31:12], HTRANSS[0]};
    assign accept = HSELS & HTRANSS[1] & HREADYS;
    assign bad = (HSIZES > 3'b010) | (HADDRS[11:6] != 6'd0) |
                 (HSIZES == 3'b001 & HADDRS[0]) |
                 (HSIZES == 3'b010 & HADDRS[1:0] != 2'b00);
    assign be = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    always_comb begin
        state_nx = IDLE;
        cnt_nx = cnt;
        if (accept) begin
            state_nx = bad ? ERR1 : OK_STATE;
            cnt_nx = CNT_INIT;
        end else if (state == WAIT) begin
            state_nx = cnt == 2'd0 ? LAST : WAIT;
            cnt_nx = cnt == 2'd0 ? 2'd0 : cnt - 2'd1;
        end else if (state == ERR1) begin
            state_nx = ERR2;
        end
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
            cnt <= 2'd0;
            addr_q <= 6'd0;
            write_q <= 1'b0;
            size_q <= 3'd0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (accept) begin
                addr_q <= HADDRS[5:0];
                write_q <= HWRITES;
                size_q <= HSIZES;
            end
            if (state == LAST && write_q)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[addr_q[5:2]][8*i +: 8] <= HWDATAS[8*i +: 8];
        end
    end
    assign HREADYOUTS = !(state == WAIT || state == ERR1);
    assign HRESPS = state == ERR1 || state == ERR2;
    assign HRDATAS = (state == LAST && !write_q) ? mem[addr_q[5:2]] : 32'h0;
endmodule

// File: tb/tb_ahb_lite_wait_slave.sv
// tb_ahb_lite_wait_slave: directed checks of a one-wait-state and a zero-wait-state slave
module tb_ahb_lite_wait_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel1, sel0, hold;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        rdy1, resp1, rdy0, resp0;
    logic [31:0] rdata1, rdata0;
    logic [31:0] rd;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    ahb_lite_wait_slave #(.WAIT_STATES(1)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSELS(sel1), .HADDRS(haddr), .HTRANSS(htrans),
        .HWRITES(hwrite), .HSIZES(hsize), .HREADYS(rdy1 & ~hold), .HWDATAS(hwdata),
        .HREADYOUTS(rdy1), .HRESPS(resp1), .HRDATAS(rdata1)
    );
    ahb_lite_wait_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSELS(sel0), .HADDRS(haddr), .HTRANSS(htrans),
        .HWRITES(hwrite), .HSIZES(hsize), .HREADYS(rdy0), .HWDATAS(hwdata),
        .HREADYOUTS(rdy0), .HRESPS(resp0), .HRDATAS(rdata0)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] s);
        haddr = a;
        hwrite = w;
        hsize = s;
        htrans = 2'b10;
    endtask
    task automatic wr1(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int k = 0;
        addr_ph(a, 1'b1, s);
        cyc();
        htrans = 2'b00;
        hwdata = d;
        while (!rdy1 && k < 8) begin
            cyc();
            k++;
        end
        if (k == 8) chk("wr1_timeout", 32'(k), 32'd0);
        cyc();
    endtask
    task automatic rd1(input logic [31:0] a, output logic [31:0] d);
        int k = 0;
        addr_ph(a, 1'b0, 3'd2);
        cyc();
        htrans = 2'b00;
        while (!rdy1 && k < 8) begin
            cyc();
            k++;
        end
        if (k == 8) chk("rd1_timeout", 32'(k), 32'd0);
        d = rdata1;
        cyc();
    endtask
    initial begin
        rst = 1'b1; sel1 = 1'b0; sel0 = 1'b0; hold = 1'b0;
        haddr = '0; hwdata = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_ready", 32'(rdy1), 32'd1);
        chk("rst_resp", 32'(resp1), 32'd0);
        chk("rst_rdata", rdata1, 32'h0);
        // one-wait-state slave: write then pipelined read of the same word
        sel1 = 1'b1;
        addr_ph(32'h08, 1'b1, 3'd2);
        cyc();
        htrans = 2'b00;
        hwdata = 32'hDEADBEEF;
        chk("w_wait_ready", 32'(rdy1), 32'd0);
        chk("w_wait_resp", 32'(resp1), 32'd0);
        cyc();
        chk("w_last_ready", 32'(rdy1), 32'd1);
        addr_ph(32'h08, 1'b0, 3'd2);
        cyc();
        htrans = 2'b00;
        chk("r_wait_ready", 32'(rdy1), 32'd0);
        chk("r_wait_rdata", rdata1, 32'h0);
        cyc();
        chk("r_last_ready", 32'(rdy1), 32'd1);
        chk("r_last_rdata", rdata1, 32'hDEADBEEF);
        cyc();
        chk("idle_rdata", rdata1, 32'h0);
        // byte and halfword lane updates
        wr1(32'h0C, 3'd2, 32'h11223344);
        wr1(32'h0D, 3'd0, 32'hFFFFA5FF);
        rd1(32'h0C, rd);
        chk("byte_write", rd, 32'h1122A544);
        wr1(32'h14, 3'd2, 32'hAABBCCDD);
        wr1(32'h16, 3'd1, 32'h12349999);
        rd1(32'h14, rd);
        chk("half_write", rd, 32'h1234CCDD);
        // misaligned word read: two-cycle error response
        addr_ph(32'h02, 1'b0, 3'd2);
        cyc();
        htrans = 2'b00;
        chk("err1_ready", 32'(rdy1), 32'd0);
        chk("err1_resp", 32'(resp1), 32'd1);
        cyc();
        chk("err2_ready", 32'(rdy1), 32'd1);
        chk("err2_resp", 32'(resp1), 32'd1);
        chk("err2_rdata", rdata1, 32'h0);
        cyc();
        chk("err_idle_ready", 32'(rdy1), 32'd1);
        chk("err_idle_resp", 32'(resp1), 32'd0);
        wr1(32'h4C, 3'd2, 32'hFFFFFFFF);
        wr1(32'h0C, 3'd3, 32'hFFFFFFFF);
        wr1(32'h0D, 3'd1, 32'hFFFFFFFF);
        rd1(32'h0C, rd);
        chk("err_no_write", rd, 32'h1122A544);
        rd1(32'h08, rd);
        chk("reg2_kept", rd, 32'hDEADBEEF);
        // IDLE and BUSY transfers keep the slave idle
        for (int i = 0; i < 5; i++) begin
            htrans = i < 3 ? 2'b00 : 2'b01;
            cyc();
            chk("idle_ready", 32'(rdy1), 32'd1);
            chk("idle_resp", 32'(resp1), 32'd0);
        end
        // HREADYS low blocks acceptance
        hold = 1'b1;
        addr_ph(32'h00, 1'b1, 3'd2);
        cyc();
        htrans = 2'b00;
        hwdata = 32'h77777777;
        hold = 1'b0;
        chk("hold_ready", 32'(rdy1), 32'd1);
        cyc();
        rd1(32'h00, rd);
        chk("hold_no_write", rd, 32'h0);
        // reset during the wait state aborts the write
        addr_ph(32'h10, 1'b1, 3'd2);
        cyc();
        htrans = 2'b00;
        hwdata = 32'h5;
        chk("pre_rst_ready", 32'(rdy1), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(rdy1), 32'd1);
        chk("mid_rst_resp", 32'(resp1), 32'd0);
        rd1(32'h10, rd);
        chk("rst_aborted", rd, 32'h0);
        rd1(32'h08, rd);
        chk("rst_cleared", rd, 32'h0);
        // zero-wait-state slave: back-to-back pipelined transfers
        sel1 = 1'b0;
        sel0 = 1'b1;
        addr_ph(32'h00, 1'b1, 3'd2);
        cyc();
        chk("z_w0_ready", 32'(rdy0), 32'd1);
        hwdata = 32'h11111111;
        addr_ph(32'h04, 1'b1, 3'd2);
        cyc();
        chk("z_w1_ready", 32'(rdy0), 32'd1);
        hwdata = 32'h22222222;
        addr_ph(32'h00, 1'b0, 3'd2);
        cyc();
        chk("z_r0_ready", 32'(rdy0), 32'd1);
        chk("z_r0_rdata", rdata0, 32'h11111111);
        addr_ph(32'h04, 1'b0, 3'd2);
        cyc();
        chk("z_r1_ready", 32'(rdy0), 32'd1);
        chk("z_r1_rdata", rdata0, 32'h22222222);
        addr_ph(32'h08, 1'b1, 3'd2);
        cyc();
        chk("z_w2_ready", 32'(rdy0), 32'd1);
        hwdata = 32'hCAFEF00D;
        addr_ph(32'h08, 1'b0, 3'd2);
        cyc();
        htrans = 2'b00;
        chk("z_fwd_rdata", rdata0, 32'hCAFEF00D);
        chk("z_fwd_resp", 32'(resp0), 32'd0);
        cyc();
        chk("z_idle_ready", 32'(rdy0), 32'd1);
        chk("z_idle_rdata", rdata0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
